// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types for the cbus arbiter slice.
//   cbus_req_t  : 151-bit master request (valid, is_write, addr, size, len, burst, data, strb)
//   cbus_resp_t : 66-bit bridge response (ready, last, data)
//   mlen_t      : burst length in AXI encoding (beats - 1)
//   arb_state_t : arbiter FSM states
package cbus_arbiter_pkg;

   localparam int AXI_BURST_LEN = 256;
   // One extra bit so the beat counter can hold AXI_BURST_LEN itself.
   localparam int BEAT_CNT_W    = $clog2(AXI_BURST_LEN) + 1;

   typedef enum logic [7:0] {
      MLEN1   = 8'd0,
      MLEN2   = 8'd1,
      MLEN4   = 8'd3,
      MLEN8   = 8'd7,
      MLEN16  = 8'd15,
      MLEN256 = 8'd255
   } mlen_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [63:0] addr;
      msize_t      size;
      mlen_t       len;
      logic [1:0]  burst;
      logic [63:0] data;
      logic [7:0]  strb;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_TURN = 2'd2
   } arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   valid : request vector
//   ptr   : highest-priority index this round
//   any   : at least one request present
//   idx   : first valid index scanning ptr, ptr+1, ... wrapping
module cbus_arbiter_rr_pick #(
   parameter  int N_REQ = 2,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   // Scan from the far end back towards ptr so the closest hit wins last.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (valid[(int'(ptr) + k) % N_REQ]) begin
            any = 1'b1;
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cache bus between N_REQ masters.
//   clk, reset_n : clock, async active-low reset
//   ireqs/iresps : per-master request in / response out
//   oreq/oresp   : request to / response from the AXI bridge
//   grant_valid  : a master owns the bus
//   grant_idx    : owning master
//   protocol_err : sticky burst protocol violation
//
// state    | meaning
// ARB_IDLE | bus free, pick next master from ptr
// ARB_BUSY | idx owns the bus until the beat carrying last
// ARB_TURN | one dead cycle so the finishing master can drop valid
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  cbus_req_t        ireqs  [N_REQ],
   output cbus_resp_t       iresps [N_REQ],
   output cbus_req_t        oreq,
   input  cbus_resp_t       oresp,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic             protocol_err
);

   arb_state_t            state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic                  err_q, err_d;

   logic [N_REQ-1:0]      req_valid;
   logic                  pick_any;
   logic [IDX_W-1:0]      pick_idx;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_valid[i] = ireqs[i].valid;
      end
   end

   cbus_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .valid (req_valid),
      .ptr   (ptr_q),
      .any   (pick_any),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      oreq       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         iresps[i] = '0;
      end

      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               idx_d      = pick_idx;
               beat_cnt_d = '0;
               state_d    = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            // Forwarded live: write data/strobe change per beat.
            oreq          = ireqs[idx_q];
            iresps[idx_q] = oresp;
            // Bursts cannot be aborted, so a dropped valid only flags an error.
            if (!ireqs[idx_q].valid) begin
               err_d = 1'b1;
            end
            if (oresp.ready) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (oresp.last) begin
                  // beat_cnt_q counts earlier beats, matching AXI len (beats-1).
                  if (beat_cnt_q != {1'b0, ireqs[idx_q].len}) begin
                     err_d = 1'b1;
                  end
                  ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                  state_d = ARB_TURN;
               end
            end
         end
         ARB_TURN: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      if (oresp.ready && !oreq.valid) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ARB_IDLE;
         ptr_q      <= '0;
         idx_q      <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   assign grant_valid  = (state_q == ARB_BUSY);
   assign grant_idx    = idx_q;
   assign protocol_err = err_q;

endmodule
